pixel_uart_serializer: RTL

//   Downstream end of the pixel stream. Accepts 16-bit pixels (pixel_valid/pixel_data)

---
 rtl/pixel_uart_serializer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/pixel_uart_serializer.sv
// pixel_uart_serializer: buffers 16-bit pixels in a small FIFO and hands them to a
// UART transmitter as two bytes each, counting pixels per frame and flagging drops.
module pixel_uart_serializer #(
    parameter int unsigned FRAME_PIXELS = 16384,
    parameter int unsigned FIFO_AW      = 4,
    parameter bit          MSB_FIRST    = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixel_valid,
    input  logic [15:0] pixel_data,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    output logic        frame_done,
    output logic [13:0] pixel_count,
    output logic        fifo_overflow,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        BYTE0,
        BYTE1
    } state_t;

    localparam int unsigned       DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(DEPTH);
    localparam logic [13:0]       LAST_PIX = 14'(FRAME_PIXELS - 1);

    // FIFO storage and bookkeeping
    logic [15:0]        mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q;
    logic [FIFO_AW-1:0] rd_ptr_q;
    logic [FIFO_AW:0]   cnt_q;
    logic               ovf_q;

    // Serializer state
    state_t      state_q, state_d;
    logic [15:0] pix_q, pix_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        frame_done_q, frame_done_d;
    logic [13:0] pix_cnt_q, pix_cnt_d;

    logic        pop;
    logic        push;
    logic        fifo_empty;
    logic        fifo_full;
    logic [15:0] head;
    logic        handshake;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FULL_CNT);
    assign head       = mem_q[rd_ptr_q];
    // A full FIFO still accepts a pixel when the serializer pops in the same cycle.
    assign push       = pixel_valid && (!fifo_full || pop);
    assign handshake  = tx_valid_q && tx_ready;

    function automatic logic [7:0] first_byte(input logic [15:0] p);
        return MSB_FIRST ? p[15:8] : p[7:0];
    endfunction

    function automatic logic [7:0] second_byte(input logic [15:0] p);
        return MSB_FIRST ? p[7:0] : p[15:8];
    endfunction

    // FIFO data array: written on accepted pixels, contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pixel_data;
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
            if (pixel_valid && !push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Serializer state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pix_q        <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
            frame_done_q <= 1'b0;
            pix_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            frame_done_q <= frame_done_d;
            pix_cnt_q    <= pix_cnt_d;
        end
    end

    // Serializer next-state: pop a pixel, emit two bytes, advance frame counter
    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        tx_valid_d   = tx_valid_q;
        tx_data_d    = tx_data_q;
        frame_done_d = 1'b0;
        pix_cnt_d    = pix_cnt_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    pix_d      = head;
                    tx_data_d  = first_byte(head);
                    tx_valid_d = 1'b1;
                    state_d    = BYTE0;
                end
            end
            BYTE0: begin
                if (handshake) begin
                    tx_data_d = second_byte(pix_q);
                    state_d   = BYTE1;
                end
            end
            BYTE1: begin
                if (handshake) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                    if (pix_cnt_q == LAST_PIX) begin
                        pix_cnt_d    = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        pix_cnt_d = pix_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    assign tx_valid      = tx_valid_q;
    assign tx_data       = tx_data_q;
    assign frame_done    = frame_done_q;
    assign pixel_count   = pix_cnt_q;
    assign fifo_overflow = ovf_q;
    assign busy          = !fifo_empty || (state_q != IDLE);

endmodule
